// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch unit with PC-tagged prefetch FIFO, redirect,
//            halt and fault handling. Optional trace/checks: FETCH_TRACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          MEM_SIZE   = 1024,
  parameter int          PC_STEP    = 4,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt_req,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        fetch_fault,
  output logic [1:0]  fetch_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t             state;
  logic [15:0]        fetch_pc;
  logic [15:0]        fifo_instr [FIFO_DEPTH];
  logic [15:0]        fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic               pop;
  logic               full;
  logic               oob;
  logic               push;
  logic               redirect_taken;

  // Bounds check is done in 17 bits so a PC near 16'hFFFF cannot wrap back in range.
  assign oob            = ({1'b0, fetch_pc} + 17'd3) >= 17'(MEM_SIZE);
  assign full           = (count == CNT_W'(FIFO_DEPTH));
  assign pop            = instr_valid && instr_ready;
  assign redirect_taken = redirect_valid && (state != ST_FAULT);
  assign push           = (state == ST_RUN) && !redirect_valid && !oob && (!full || pop);

  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
  assign fetch_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_fault <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (redirect_taken) begin
      // Flush discards any same-cycle pop along with the buffered entries.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (redirect_pc[1:0] == 2'b00) begin
        fetch_pc <= redirect_pc;
        state    <= ST_RUN;
      end else begin
        state       <= ST_FAULT;
        fetch_fault <= 1'b1;
      end
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= imem_instr;
        fifo_pc[wr_ptr]    <= fetch_pc;
        wr_ptr             <= wr_ptr + 1'b1;
        fetch_pc           <= fetch_pc + 16'(PC_STEP);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      case (state)
        ST_RUN: begin
          if (oob) begin
            state       <= ST_FAULT;
            fetch_fault <= 1'b1;
          end else if (halt_req) begin
            state <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (!halt_req) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_FAULT;
      endcase
    end
  end

`ifdef FETCH_TRACE_EN
  logic enter_fault;
  assign enter_fault = (state != ST_FAULT) &&
                       ((redirect_taken && redirect_pc[1:0] != 2'b00) ||
                        (!redirect_valid && state == ST_RUN && oob));

  always @(posedge clk) begin
    if (rst_n) begin
      if (pop && !redirect_taken) begin
        $display("%0t fetch pop pc=%h instr=%b", $time, instr_pc, instr);
      end
      if (enter_fault) begin
        $display("%0t fetch fault addr=%h", $time,
                 redirect_taken ? redirect_pc : fetch_pc);
      end
      assert (imem_addr[1:0] == 2'b00);
      if (push) begin
        assert (!$isunknown(imem_instr));
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Directed self-checking bench for instr_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        fetch_fault;
  logic [1:0]  fetch_state;

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault),
    .fetch_state    (fetch_state)
  );

  // ROM word at byte address a is 16'hC000 | (a/4).
  assign imem_instr = 16'hC000 | (imem_addr >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    halt_req       = 1'b0;
    instr_ready    = 1'b1;
    step(2);

    // Reset state
    chk("rst_addr",  {16'h0, imem_addr}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", {16'h0, instr}, 32'h0);
    chk("rst_pc",    {16'h0, instr_pc}, 32'h0);
    chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
    chk("rst_state", {30'h0, fetch_state}, 32'h0);

    // Streaming fetch with decode always ready
    #1 rst_n = 1'b1;
    step(1);
    chk("s1_addr",  {16'h0, imem_addr}, 32'h4);
    chk("s1_valid", {31'h0, instr_valid}, 32'h1);
    chk("s1_pc",    {16'h0, instr_pc}, 32'h0);
    chk("s1_instr", {16'h0, instr}, 32'hC000);
    step(1);
    chk("s2_addr",  {16'h0, imem_addr}, 32'h8);
    chk("s2_pc",    {16'h0, instr_pc}, 32'h4);
    chk("s2_instr", {16'h0, instr}, 32'hC001);
    step(1);
    chk("s3_addr",  {16'h0, imem_addr}, 32'hC);
    chk("s3_pc",    {16'h0, instr_pc}, 32'h8);
    chk("s3_instr", {16'h0, instr}, 32'hC002);

    // Backpressure: FIFO saturates at two entries
    instr_ready = 1'b0;
    do_reset();
    step(5);
    chk("bp_addr",  {16'h0, imem_addr}, 32'h8);
    chk("bp_pc",    {16'h0, instr_pc}, 32'h0);
    chk("bp_valid", {31'h0, instr_valid}, 32'h1);
    instr_ready = 1'b1;
    step(1);
    chk("bp_rel1_pc",   {16'h0, instr_pc}, 32'h4);
    chk("bp_rel1_addr", {16'h0, imem_addr}, 32'hC);
    step(1);
    chk("bp_rel2_pc",    {16'h0, instr_pc}, 32'h8);
    chk("bp_rel2_valid", {31'h0, instr_valid}, 32'h1);
    chk("bp_rel2_addr",  {16'h0, imem_addr}, 32'h10);

    // Redirect while full, with a pop that must be discarded
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    step(1);
    redirect_valid = 1'b0;
    chk("rd_valid", {31'h0, instr_valid}, 32'h0);
    chk("rd_addr",  {16'h0, imem_addr}, 32'h40);
    step(1);
    chk("rd_pc",    {16'h0, instr_pc}, 32'h40);
    chk("rd_instr", {16'h0, instr}, 32'hC010);

    // Halt with two entries buffered
    instr_ready = 1'b0;
    step(1);
    chk("h_fill_addr", {16'h0, imem_addr}, 32'h48);
    halt_req = 1'b1;
    step(1);
    chk("h_state", {30'h0, fetch_state}, 32'h1);
    chk("h_addr",  {16'h0, imem_addr}, 32'h48);
    instr_ready = 1'b1;
    step(1);
    chk("h_drain1_pc",    {16'h0, instr_pc}, 32'h44);
    chk("h_drain1_valid", {31'h0, instr_valid}, 32'h1);
    step(1);
    chk("h_drain2_valid", {31'h0, instr_valid}, 32'h0);
    step(2);
    chk("h_idle_valid", {31'h0, instr_valid}, 32'h0);
    chk("h_idle_addr",  {16'h0, imem_addr}, 32'h48);
    halt_req = 1'b0;
    step(1);
    chk("h_resume_state", {30'h0, fetch_state}, 32'h0);
    step(1);
    chk("h_resume_pc",    {16'h0, instr_pc}, 32'h48);
    chk("h_resume_instr", {16'h0, instr}, 32'hC012);

    // Run to the end of memory
    redirect_valid = 1'b1;
    redirect_pc    = 16'd1012;
    step(1);
    redirect_valid = 1'b0;
    step(3);
    chk("end_pc",    {16'h0, instr_pc}, 32'd1020);
    chk("end_instr", {16'h0, instr}, 32'hC0FF);
    chk("end_state", {30'h0, fetch_state}, 32'h0);
    chk("end_addr",  {16'h0, imem_addr}, 32'd1024);
    step(1);
    chk("oob_fault", {31'h0, fetch_fault}, 32'h1);
    chk("oob_state", {30'h0, fetch_state}, 32'h2);
    chk("oob_valid", {31'h0, instr_valid}, 32'h0);
    chk("oob_addr",  {16'h0, imem_addr}, 32'd1024);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    step(1);
    redirect_valid = 1'b0;
    chk("oob_ign_addr",  {16'h0, imem_addr}, 32'd1024);
    chk("oob_ign_state", {30'h0, fetch_state}, 32'h2);
    do_reset();
    chk("clr_fault", {31'h0, fetch_fault}, 32'h0);
    chk("clr_state", {30'h0, fetch_state}, 32'h0);
    chk("clr_addr",  {16'h0, imem_addr}, 32'h0);

    // Misaligned redirect
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0042;
    step(1);
    redirect_valid = 1'b0;
    chk("mis_fault", {31'h0, fetch_fault}, 32'h1);
    chk("mis_state", {30'h0, fetch_state}, 32'h2);
    chk("mis_valid", {31'h0, instr_valid}, 32'h0);
    chk("mis_addr",  {16'h0, imem_addr}, 32'h4);
    step(3);
    chk("mis_hold_valid", {31'h0, instr_valid}, 32'h0);
    chk("mis_hold_addr",  {16'h0, imem_addr}, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit: the initiator side of the instruction ROM interface.
- Drives the 16-bit word-aligned byte address to the combinational instruction ROM and captures the returned 16-bit instruction.
- Buffers fetched instructions, each tagged with its PC, in a small prefetch FIFO and presents them to decode via a valid/ready handshake.
- Handles branch redirects, halt requests and out-of-bounds fetch faults.

Parameters:
- RESET_PC, 16'h0000, first fetch address after reset; bits [1:0] must be 0.
- MEM_SIZE, 1024, ROM size in bytes; power of two.
- PC_STEP, 4, byte increment between sequential instructions (one 16-bit instruction per 4-byte slot).
- FIFO_DEPTH, 2, prefetch buffer entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_addr  output  16  byte address to instruction ROM
- imem_instr  input  16  instruction returned combinationally for imem_addr
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_pc  input  16  redirect target byte address
- halt_req  input  1  stop fetching (level)
- instr_valid  output  1  instr/instr_pc valid to decode
- instr_ready  input  1  decode accepts head entry
- instr  output  16  head instruction
- instr_pc  output  16  byte address of head instruction
- fetch_fault  output  1  sticky fault flag
- fetch_state  output  2  RUN=0, HALT=1, FAULT=2

Behaviour:
- Reset (async on rst_n low): fetch_pc=RESET_PC, FIFO empty, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0, state RUN.
- imem_addr = fetch_pc, directly from the register (no combinational path from inputs).
- Push condition, RUN only: no redirect, address in bounds, and (count<FIFO_DEPTH or pop this cycle).
- On push: write {imem_instr, fetch_pc} at the tail; fetch_pc += PC_STEP, modulo 2^16.
- Pop: instr_valid && instr_ready. Pop and push in the same cycle are allowed, including when the FIFO is full; count is unchanged.
- instr, instr_pc and instr_valid come from the FIFO head. instr_valid = (count != 0).
- Latency: after reset release, the first instruction is valid on the cycle following the first push edge. Sustained throughput is one instruction per cycle while instr_ready=1.
- FIFO full and no pop: fetch_pc holds, imem_addr is stable, no push.
- Redirect has the highest priority, in RUN or HALT:
  - FIFO flushed (count=0); any pop that cycle is discarded.
  - No push that cycle.
  - If redirect_pc[1:0]==0: fetch_pc<=redirect_pc, state<=RUN, even if halt_req=1 that cycle.
  - If redirect_pc[1:0]!=0: state<=FAULT, fetch_fault<=1, fetch_pc unchanged.
- HALT: entered from RUN when halt_req=1 and no redirect. No pushes. The FIFO continues to drain to decode. Returns to RUN when halt_req=0, or on an aligned redirect.
- Bounds check: when fetch_pc+3 >= MEM_SIZE in RUN (computed 17-bit, no wrap), there is no push; state<=FAULT, fetch_fault<=1.
- FAULT: no pushes; redirect and halt_req are ignored; the FIFO still drains. Only rst_n exits FAULT. fetch_fault stays 1 until reset.
- Reset mid-operation: all state clears immediately; in-flight FIFO contents are lost.
- fetch_state reflects the current registered state.

Optional Feature:
- Macro: FETCH_TRACE_EN.
- Defined:
  - On every pop, $display prints time, instr_pc (hex) and instr (binary).
  - On entry to FAULT, the message includes the offending address.
  - Assertions check that imem_addr[1:0]==0 at every clock edge and that imem_instr is not X on any push.
- Undefined: no display or assertion code is compiled; functional behaviour is identical.

Test Plan:
- Reset release with RESET_PC=0 and instr_ready=1 -> imem_addr sequence 0,4,8,12; decode receives instr_pc 0,4,8 on consecutive cycles with instr matching the ROM words at indices 0,1,2.
- Hold instr_ready=0 for 5 cycles -> count saturates at 2, imem_addr frozen at 8, instr_pc stays 0; release -> pops 0,4, then 8 follows with no bubble.
- redirect_valid=1, redirect_pc=16'h0040 while FIFO is full -> next cycle instr_valid=0, imem_addr=16'h0040; the following cycle instr_pc=16'h0040.
- halt_req=1 with 2 entries buffered -> state HALT, both entries drain, then instr_valid=0 and imem_addr constant; halt_req=0 -> fetching resumes from the held address.
- Sequential fetch reaches fetch_pc=1020 (MEM_SIZE=1024) -> 1020 is pushed; at 1024 fetch_fault=1 and state FAULT; a redirect to 0 is ignored; rst_n pulse clears the fault.
- redirect_pc=16'h0042 -> fetch_fault=1, state FAULT, FIFO empty, no further pushes.
